xif_copro_commit_ctrl: RTL
==========================

# xif_copro_commit_ctrl

In-order issue/commit controller placed between the CORE-V-XIF issue/commit/result channels and the coprocessor execution stage. It buffers offloaded instructions in program order and holds each one until the core commits or kills it. It dispatches only committed instructions to the single-entry execution stage. Execution results pass through a one-entry result register to the XIF result channel.

## Interface
- XLEN, 64, operand/result width
- DEPTH, 4, instruction buffer entries; power of two, ≥2
- ID_WIDTH, 4, XIF instruction id width; also the tag width toward the execution stage
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  offloaded instruction valid
- issue_ready_o  out  1  buffer can accept
- issue_id_i  in  ID_WIDTH  instruction id
- issue_op_i  in  copro_op_e  decoded operator (xif_copro_pkg)
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands
- commit_valid_i  in  1  commit event (no ready; always accepted)
- commit_id_i  in  ID_WIDTH  committed/killed id
- commit_kill_i  in  1  1 = kill, 0 = commit
- ex_valid_o  out  1  dispatch valid toward execution stage
- ex_ready_i  in  1  execution stage ready
- ex_operand_a_o, ex_operand_b_o  out  XLEN  rs1/rs2 of head entry
- ex_operator_o  out  copro_op_e  head operator
- ex_tag_o  out  ID_WIDTH  head id
- ex_valid_i  in  1  execution result valid
- ex_ready_o  out  1  result register can accept
- ex_tag_i  in  ID_WIDTH  result id
- ex_result_i  in  XLEN  result data
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  ID_WIDTH  result id
- result_data_o  out  XLEN  result data
- inflight_o  out  $clog2(DEPTH+1)  occupied buffer entries
- err_o  out  1  sticky protocol error

## Operation
- Circular buffer with head (oldest), commit pointer (oldest uncommitted), and tail (next write). All pointers wrap modulo DEPTH. Per-entry state: PENDING, COMMITTED, or KILLED.
- Issue: issue_valid_i & issue_ready_o writes {id, op, rs1, rs2, PENDING} at tail; tail++.
- issue_ready_o = (count < DEPTH). It does not depend on a same-cycle pop.
- Commit: commit_valid_i targets the entry at the commit pointer.
  - The target entry must exist and hold commit_id_i.
  - On match: state ← KILLED if commit_kill_i, else COMMITTED; commit pointer++.
  - A commit on the entry being issued in the same cycle (buffer otherwise fully committed, ids match) is applied to the new entry.
  - Mismatched id, or no uncommitted entry: commit ignored, err_o ← 1.
- Head handling:
  - Head COMMITTED: ex_valid_o = 1, ex_* = head fields. Pop on ex_valid_o & ex_ready_i.
  - Head KILLED: popped at the next edge without dispatch; ex_valid_o = 0 that cycle.
  - Head PENDING or buffer empty: ex_valid_o = 0.
  - At most one pop per cycle.
- Result: ex_ready_o = ~result_valid_o | result_ready_i.
  - ex_valid_i & ex_ready_o loads {ex_tag_i, ex_result_i} and sets result_valid_o.
  - result_valid_o & result_ready_i with no new load clears result_valid_o.
  - Load and drain in the same cycle keeps result_valid_o = 1 with the new data.
- inflight_o = count. Issue with pop in the same cycle leaves count unchanged.
- err_o is cleared only by reset.

## Timing
- Reset values (asynchronous, immediate on rst_i): count 0, all pointers 0, all states PENDING. Outputs: issue_ready_o 1, ex_valid_o 0, ex_* 0, ex_ready_o 1, result_valid_o 0, result_id_o 0, result_data_o 0, inflight_o 0, err_o 0.
- Reset asserted mid-operation discards all buffered instructions and the result register with no outputs.
- Issue at edge t with commit in the same cycle: ex_valid_o at t+1 at the earliest (zero bypass from issue to dispatch).
- Each killed entry costs one cycle at the head.
- Result latency: ex_valid_i handshake at edge t gives result_valid_o = 1 at t+1.
- Full buffer: issue_ready_o = 0 until a pop edge; issue_ready_o = 1 in the following cycle.
- ex_* outputs are held stable while ex_valid_o & ~ex_ready_i.
- result_id_o and result_data_o are held stable while result_valid_o & ~result_ready_i.

## Test plan
- Issue id 3 BITREV rs1=0x1 and commit id 3 in the same cycle, ex_ready_i = 1. Required: ex_valid_o at the next cycle with ex_tag_o = 3 and ex_operand_a_o = 0x1. After ex returns result 0x8000_0000_0000_0000, result_valid_o = 1 one cycle later with result_id_o = 3.
- Issue ids 0–3 with no commits. Required: inflight_o = 4, issue_ready_o = 0, ex_valid_o = 0. Commit id 0, then issue id 4 in the cycle after the pop. Required: accepted, inflight_o returns to 4.
- Issue ids 1, 2, 3; kill id 1, commit 2, commit 3. Required: id 1 never appears on ex_tag_o; ex_tag_o sequence is 2 then 3; one bubble cycle for the killed head.
- Commit id 5 while the commit pointer entry holds id 1, and separately commit with an empty buffer. Required: both ignored, err_o = 1 and stays 1; buffer contents unchanged.
- Hold result_ready_i = 0 with result_valid_o = 1 while ex_valid_i = 1. Required: ex_ready_o = 0 and result_* stable. Then set result_ready_i = 1 with ex_valid_i = 1. Required: result_valid_o stays 1 with the new id the next cycle.
- Assert rst_i with 3 entries buffered and a result pending. Required: all outputs take reset values immediately; after release, no stale ex_valid_o or result_valid_o.

Source files
------------

// File: rtl/xif_copro_commit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : xif_copro_pkg / xif_copro_commit_ctrl_if
// Purpose  : Shared coprocessor operator type plus the bundled issue, commit,
//            dispatch and result channels of the commit controller.
// Ports    : issue_*  - offload from core (valid/ready)
//            commit_* - commit/kill events (no backpressure)
//            ex_*     - dispatch to and results from the execution stage
//            result_* - XIF result channel (valid/ready)
//            inflight_o, err_o - status
// Modports : slave  - the commit controller
//            master - the surrounding core / execution stage / testbench
// Revision : 1.0 - initial release
// ============================================================================

package xif_copro_pkg;
  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_BITREV = 3'd5,
    OP_CLZ    = 3'd6,
    OP_POPCNT = 3'd7
  } copro_op_e;
endpackage

interface xif_copro_commit_ctrl_if #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
);
  import xif_copro_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  // issue channel
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [ID_WIDTH-1:0] issue_id_i;
  copro_op_e           issue_op_i;
  logic [XLEN-1:0]     issue_rs1_i;
  logic [XLEN-1:0]     issue_rs2_i;
  // commit channel
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  // dispatch toward execution stage
  logic                ex_valid_o;
  logic                ex_ready_i;
  logic [XLEN-1:0]     ex_operand_a_o;
  logic [XLEN-1:0]     ex_operand_b_o;
  copro_op_e           ex_operator_o;
  logic [ID_WIDTH-1:0] ex_tag_o;
  // results from execution stage
  logic                ex_valid_i;
  logic                ex_ready_o;
  logic [ID_WIDTH-1:0] ex_tag_i;
  logic [XLEN-1:0]     ex_result_i;
  // result channel
  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [XLEN-1:0]     result_data_o;
  // status
  logic [CNT_W-1:0]    inflight_o;
  logic                err_o;

  modport slave (
    input  issue_valid_i, issue_id_i, issue_op_i, issue_rs1_i, issue_rs2_i,
    output issue_ready_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output ex_valid_o, ex_operand_a_o, ex_operand_b_o, ex_operator_o, ex_tag_o,
    input  ex_ready_i,
    input  ex_valid_i, ex_tag_i, ex_result_i,
    output ex_ready_o,
    output result_valid_o, result_id_o, result_data_o,
    input  result_ready_i,
    output inflight_o, err_o
  );

  modport master (
    output issue_valid_i, issue_id_i, issue_op_i, issue_rs1_i, issue_rs2_i,
    input  issue_ready_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  ex_valid_o, ex_operand_a_o, ex_operand_b_o, ex_operator_o, ex_tag_o,
    output ex_ready_i,
    output ex_valid_i, ex_tag_i, ex_result_i,
    input  ex_ready_o,
    input  result_valid_o, result_id_o, result_data_o,
    output result_ready_i,
    input  inflight_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/xif_copro_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xif_copro_commit_ctrl
// Purpose  : In-order issue/commit controller. Buffers offloaded instructions
//            in program order, holds each until committed or killed, and
//            dispatches committed ones to a single-entry execution stage.
//            Execution results pass through a one-entry result register.
// Ports    : clk_i - clock, rising edge
//            rst_i - asynchronous active-high reset
//            bus   - issue/commit/dispatch/result channels (slave modport)
// Revision : 1.0 - initial release
// ============================================================================

module xif_copro_commit_ctrl
  import xif_copro_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  xif_copro_commit_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_PENDING   = 2'd0;
  localparam logic [1:0] ST_COMMITTED = 2'd1;
  localparam logic [1:0] ST_KILLED    = 2'd2;

  // instruction buffer
  logic [ID_WIDTH-1:0] r_id  [DEPTH];
  copro_op_e           r_op  [DEPTH];
  logic [XLEN-1:0]     r_rs1 [DEPTH];
  logic [XLEN-1:0]     r_rs2 [DEPTH];
  logic [1:0]          r_st  [DEPTH];

  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_cptr;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  // entries between head and commit pointer (already committed or killed)
  logic [CNT_W-1:0]    r_resolved;
  logic                r_err;

  // result register
  logic                r_res_valid;
  logic [ID_WIDTH-1:0] r_res_id;
  logic [XLEN-1:0]     r_res_data;

  logic       w_empty;
  logic       w_issue_ready;
  logic       w_issue_fire;
  logic [1:0] w_head_st;
  logic       w_ex_valid;
  logic       w_pop;
  logic       w_has_uncommitted;
  logic       w_commit_old;
  logic       w_commit_new;
  logic       w_commit_ok;
  logic       w_commit_err;
  logic [1:0] w_commit_st;
  logic       w_ex_ready;
  logic       w_res_load;

  assign w_empty       = (r_count == '0);
  assign w_issue_ready = (r_count < CNT_W'(DEPTH));
  assign w_issue_fire  = bus.issue_valid_i & w_issue_ready;
  assign w_head_st     = r_st[r_head];
  assign w_ex_valid    = ~w_empty & (w_head_st == ST_COMMITTED);
  // a killed head drains without dispatch; at most one pop per cycle
  assign w_pop         = ~w_empty & ((w_head_st == ST_KILLED) |
                                     ((w_head_st == ST_COMMITTED) & bus.ex_ready_i));

  assign w_has_uncommitted = (r_count != r_resolved);
  assign w_commit_old = bus.commit_valid_i & w_has_uncommitted &
                        (r_id[r_cptr] == bus.commit_id_i);
  // with nothing uncommitted the commit pointer equals the tail, so a commit
  // matching the instruction issued this cycle lands on the new entry
  assign w_commit_new = bus.commit_valid_i & ~w_has_uncommitted & w_issue_fire &
                        (bus.issue_id_i == bus.commit_id_i);
  assign w_commit_ok  = w_commit_old | w_commit_new;
  assign w_commit_err = bus.commit_valid_i & ~w_commit_ok;
  assign w_commit_st  = bus.commit_kill_i ? ST_KILLED : ST_COMMITTED;

  assign w_ex_ready = ~r_res_valid | bus.result_ready_i;
  assign w_res_load = bus.ex_valid_i & w_ex_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]  <= '0;
        r_op[i]  <= OP_ADD;
        r_rs1[i] <= '0;
        r_rs2[i] <= '0;
        r_st[i]  <= ST_PENDING;
      end
      r_head     <= '0;
      r_cptr     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_resolved <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_issue_fire) begin
        r_id[r_tail]  <= bus.issue_id_i;
        r_op[r_tail]  <= bus.issue_op_i;
        r_rs1[r_tail] <= bus.issue_rs1_i;
        r_rs2[r_tail] <= bus.issue_rs2_i;
        r_st[r_tail]  <= ST_PENDING;
        r_tail        <= r_tail + PTR_W'(1);
      end
      // placed after the issue write so a same-cycle commit overrides PENDING
      if (w_commit_ok) begin
        r_st[r_cptr] <= w_commit_st;
        r_cptr       <= r_cptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count    <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_pop);
      r_resolved <= r_resolved + CNT_W'(w_commit_ok) - CNT_W'(w_pop);
      if (w_commit_err) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else if (w_res_load) begin
      r_res_valid <= 1'b1;
      r_res_id    <= bus.ex_tag_i;
      r_res_data  <= bus.ex_result_i;
    end else if (bus.result_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.issue_ready_o  = w_issue_ready;
  assign bus.ex_valid_o     = w_ex_valid;
  assign bus.ex_operand_a_o = r_rs1[r_head];
  assign bus.ex_operand_b_o = r_rs2[r_head];
  assign bus.ex_operator_o  = r_op[r_head];
  assign bus.ex_tag_o       = r_id[r_head];
  assign bus.ex_ready_o     = w_ex_ready;
  assign bus.result_valid_o = r_res_valid;
  assign bus.result_id_o    = r_res_id;
  assign bus.result_data_o  = r_res_data;
  assign bus.inflight_o     = r_count;
  assign bus.err_o          = r_err;

endmodule

`default_nettype wire
